// File: rtl/floppy_input_conditioner.sv
// N-channel conditioner for floppy drive status lines: sync, optional invert, glitch filter, strobes.
// Define FLOPPY_INDEX_PERIOD_EN to build the index-period meter on channel INDEX_CH.
module floppy_input_conditioner #(
   parameter int                NUM_CH      = 6,
   parameter int                FILTER_LEN  = 4,
   parameter int                CNT_W       = 3,
   parameter logic [NUM_CH-1:0] INVERT_MASK = '0,
   parameter int                INDEX_CH    = 4,
   parameter int                PERIOD_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   raw_in,
   output logic [NUM_CH-1:0]   filt_out,
   output logic [NUM_CH-1:0]   rise_stb,
   output logic [NUM_CH-1:0]   fall_stb,
   output logic [NUM_CH-1:0]   glitch_stb,
   output logic [PERIOD_W-1:0] index_period,
   output logic                period_valid,
   output logic                period_ovf
);

   logic [NUM_CH-1:0] sync1, sync2, s;
   logic [NUM_CH-1:0] accept, abandon;
   logic [CNT_W-1:0]  cnt [NUM_CH];

   // Sync flops reset to the inactive level so inverted channels see no event on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= INVERT_MASK;
         sync2 <= INVERT_MASK;
      end else begin
         // NOTE: non-blocking so sync2 takes the old sync1, giving two real flop stages.
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ INVERT_MASK;

   always_comb begin
      accept  = '0;
      abandon = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         accept[i]  = (s[i] != filt_out[i]) && (cnt[i] == CNT_W'(FILTER_LEN - 1));
         abandon[i] = (s[i] == filt_out[i]) && (cnt[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_out   <= '0;
         rise_stb   <= '0;
         fall_stb   <= '0;
         glitch_stb <= '0;
         // NOTE: these counters are per-channel state, not storage, so they must reset.
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else begin
         rise_stb   <= accept & s;
         fall_stb   <= accept & ~s;
         glitch_stb <= abandon;
         for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
               filt_out[i] <= s[i];
               cnt[i]      <= '0;
            end else if (s[i] != filt_out[i]) begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

`ifdef FLOPPY_INDEX_PERIOD_EN
   logic                index_rise;
   logic                armed;
   logic [PERIOD_W-1:0] per_cnt;

   // Same edge on which filt_out[INDEX_CH] rises, so the period is the exact strobe distance.
   assign index_rise = accept[INDEX_CH] & s[INDEX_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed        <= 1'b0;
         per_cnt      <= '0;
         index_period <= '0;
         period_valid <= 1'b0;
         period_ovf   <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (index_rise) begin
            if (armed) begin
               index_period <= per_cnt;
               period_ovf   <= &per_cnt;
               period_valid <= 1'b1;
            end
            armed   <= 1'b1;
            per_cnt <= PERIOD_W'(1);
         end else if (armed && !(&per_cnt)) begin
            per_cnt <= per_cnt + PERIOD_W'(1);
         end
      end
   end
`else
   assign index_period = '0;
   assign period_valid = 1'b0;
   assign period_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_floppy_input_conditioner.sv
// Directed bench for floppy_input_conditioner: filter timing, inversion, strobes, index meter.
// Two instances share stimulus: u_dut (32-bit period, ch2 inverted) and u_dut8 (8-bit period).
module tb_floppy_input_conditioner;

`ifdef FLOPPY_INDEX_PERIOD_EN
   localparam bit METER = 1'b1;
`else
   localparam bit METER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  raw_in;
   logic [5:0]  filt_out, rise_stb, fall_stb, glitch_stb;
   logic [31:0] index_period;
   logic        period_valid, period_ovf;
   logic [5:0]  filt8, rise8, fall8, glitch8;
   logic [7:0]  index_period8;
   logic        period_valid8, period_ovf8;

   int checks = 0;
   int errors = 0;

   floppy_input_conditioner #(.INVERT_MASK(6'b000100), .PERIOD_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
      .filt_out(filt_out), .rise_stb(rise_stb), .fall_stb(fall_stb), .glitch_stb(glitch_stb),
      .index_period(index_period), .period_valid(period_valid), .period_ovf(period_ovf)
   );

   floppy_input_conditioner #(.INVERT_MASK(6'b000100), .PERIOD_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
      .filt_out(filt8), .rise_stb(rise8), .fall_stb(fall8), .glitch_stb(glitch8),
      .index_period(index_period8), .period_valid(period_valid8), .period_ovf(period_ovf8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One INDEX rise followed by a low stretch, so the next call's rise lands `gap` cycles later.
   task automatic idx(input int gap, input bit v, input int p, input bit o, input int p8, input bit o8);
      raw_in[4] = 1'b1;
      step(6);
      check("idx_rise", 32'(rise_stb[4]), 32'd1);
      check("idx_valid", 32'(period_valid), 32'(v & METER));
      check("idx_period", index_period, METER ? 32'(p) : 32'd0);
      check("idx_ovf", 32'(period_ovf), 32'(o & METER));
      check("idx_valid8", 32'(period_valid8), 32'(v & METER));
      check("idx_period8", 32'(index_period8), METER ? 32'(p8) : 32'd0);
      check("idx_ovf8", 32'(period_ovf8), 32'(o8 & METER));
      step(1);
      check("idx_valid_drop", 32'(period_valid), 32'd0);
      check("idx_period_hold", index_period, METER ? 32'(p) : 32'd0);
      step(13);
      raw_in[4] = 1'b0;
      step(gap - 20);
   endtask

   initial begin
      rst_n  = 1'b0;
      raw_in = 6'b000100;
      step(3);
      check("rst_filt", 32'(filt_out), 32'd0);
      check("rst_strobes", 32'(rise_stb | fall_stb | glitch_stb), 32'd0);
      check("rst_period", index_period, 32'd0);
      check("rst_valid_ovf", 32'({period_valid, period_ovf}), 32'd0);
      rst_n = 1'b1;
      step(10);
      check("inv_idle_filt", 32'(filt_out), 32'd0);
      check("inv_idle_strobes", 32'(rise_stb | fall_stb | glitch_stb), 32'd0);

      // 3-cycle pulse is rejected with one glitch strobe
      raw_in[4] = 1'b1;
      step(3);
      raw_in[4] = 1'b0;
      step(3);
      check("short_glitch", 32'(glitch_stb), 32'h10);
      check("short_filt", 32'(filt_out), 32'd0);
      check("short_rise", 32'(rise_stb), 32'd0);
      step(1);
      check("short_glitch_drop", 32'(glitch_stb), 32'd0);

      // held level: accepted at edge N+5; this first INDEX rise only arms the meter
      raw_in[4] = 1'b1;
      step(5);
      check("lat_before", 32'(filt_out), 32'd0);
      step(1);
      check("lat_filt", 32'(filt_out), 32'h10);
      check("lat_rise", 32'(rise_stb), 32'h10);
      check("arm_no_valid", 32'(period_valid), 32'd0);
      step(1);
      check("lat_rise_drop", 32'(rise_stb), 32'd0);
      step(13);
      raw_in[4] = 1'b0;
      step(5);
      check("fall_before", 32'(filt_out), 32'h10);
      step(1);
      check("fall_stb", 32'(fall_stb), 32'h10);
      check("fall_filt", 32'(filt_out), 32'd0);
      step(974);

      // gaps 1000, 1000, 300, 100 (8-bit instance saturates on the first three)
      idx(1000, 1, 1000, 0, 255, 1);
      idx(300,  1, 1000, 0, 255, 1);
      idx(100,  1, 300,  0, 255, 1);
      idx(30,   1, 100,  0, 100, 0);

      // inverted channel 2
      raw_in[2] = 1'b0;
      step(5);
      check("inv_before", 32'(filt_out), 32'd0);
      step(1);
      check("inv_filt", 32'(filt_out), 32'h04);
      check("inv_rise", 32'(rise_stb), 32'h04);
      step(1);
      check("inv_rise_drop", 32'(rise_stb), 32'd0);
      raw_in[2] = 1'b1;
      step(6);
      check("inv_fall", 32'(fall_stb), 32'h04);
      check("inv_fall_filt", 32'(filt_out), 32'd0);

      // exactly FILTER_LEN-cycle pulse on ch1 with ch0 rising in the same cycle
      raw_in = 6'b000111;
      step(4);
      raw_in = 6'b000101;
      step(2);
      check("min_pulse_filt", 32'(filt_out), 32'h03);
      check("min_pulse_rise", 32'(rise_stb), 32'h03);
      step(4);
      check("min_pulse_fall", 32'(fall_stb), 32'h02);
      check("min_pulse_filt2", 32'(filt_out), 32'h01);
      raw_in = 6'b000100;
      step(10);
      check("quiet_filt", 32'(filt_out), 32'd0);

      // reset mid-filter (ch0 count at 2) with meter armed and ch5 filtered high
      raw_in = 6'b100100;
      step(10);
      check("pre_rst_filt", 32'(filt_out), 32'h20);
      raw_in = 6'b100101;
      step(4);
      rst_n = 1'b0;
      #2;
      check("mid_rst_filt", 32'(filt_out), 32'd0);
      check("mid_rst_strobes", 32'(rise_stb | fall_stb | glitch_stb), 32'd0);
      check("mid_rst_period", index_period, 32'd0);
      check("mid_rst_ovf_valid", 32'({period_valid, period_ovf, period_ovf8}), 32'd0);
      check("mid_rst_period8", 32'(index_period8), 32'd0);
      step(1);
      rst_n = 1'b1;
      step(5);
      check("post_rst_discard", 32'(filt_out), 32'd0);
      step(1);
      check("post_rst_filt", 32'(filt_out), 32'h21);
      check("post_rst_rise", 32'(rise_stb), 32'h21);

      idx(500, 0, 0, 0, 0, 0);
      idx(30, 1, 500, 0, 255, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
